// File: rtl/l2_arbiter_rr_if.sv
// Requester/L2 bus bundle for l2_arbiter_rr; the arbiter takes the master
// modport (it drives the L2 side), caches and L2 model take the slave modport.
interface l2_arbiter_rr_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*LINE_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_read;
    logic [NUM_REQ-1:0]            req_write;
    logic [LINE_WIDTH-1:0]         req_rdata;
    logic [NUM_REQ-1:0]            req_resp;
    logic [ADDR_WIDTH-1:0]         l2_addr;
    logic [LINE_WIDTH-1:0]         l2_wdata;
    logic                          l2_read;
    logic                          l2_write;
    logic [LINE_WIDTH-1:0]         l2_rdata;
    logic                          l2_resp;
    logic [GRANT_W-1:0]            grant_idx;

    modport master (
        input  req_addr, req_wdata, req_read, req_write, l2_rdata, l2_resp,
        output req_rdata, req_resp, l2_addr, l2_wdata, l2_read, l2_write, grant_idx
    );

    modport slave (
        output req_addr, req_wdata, req_read, req_write, l2_rdata, l2_resp,
        input  req_rdata, req_resp, l2_addr, l2_wdata, l2_read, l2_write, grant_idx
    );
endinterface

// File: rtl/l2_arbiter_rr.sv
// N-port cache-to-L2 arbiter, round-robin or fixed priority, one transaction in flight.
// state | meaning
// IDLE  | pick a winner among pending requesters, register its command
// BUSY  | command held on L2; l2_resp completes it to the granted requester
// DONE  | one recovery cycle so the finished requester can drop its request
module l2_arbiter_rr #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int ARB_MODE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    l2_arbiter_rr_if.master   bus
);
    localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                 r_state;
    logic [GRANT_W-1:0]     r_last_grant;
    logic [GRANT_W-1:0]     r_grant_idx;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [LINE_WIDTH-1:0]  r_wdata;
    logic                   r_read;
    logic                   r_write;

    logic [NUM_REQ-1:0]     w_pending;
    logic                   w_any;
    logic [GRANT_W-1:0]     w_win;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [LINE_WIDTH-1:0]  w_sel_wdata;
    logic                   w_sel_write;
    logic [NUM_REQ-1:0]     w_resp;

    assign w_pending = bus.req_read | bus.req_write;
    assign w_any     = |w_pending;

    // Both loops run from lowest to highest precedence so the last hit wins.
    always_comb begin
        w_win = '0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (w_pending[i]) w_win = GRANT_W'(i);
            end
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                if (w_pending[(int'(r_last_grant) + k) % NUM_REQ])
                    w_win = GRANT_W'((int'(r_last_grant) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == GRANT_W'(i)) begin
                w_sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = bus.req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
                w_sel_write = bus.req_write[i];
            end
        end
    end

    always_comb begin
        w_resp = '0;
        if (r_state == S_BUSY && bus.l2_resp) w_resp[r_grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= GRANT_W'(NUM_REQ - 1);
            r_grant_idx  <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state      <= S_BUSY;
                        r_grant_idx  <= w_win;
                        r_last_grant <= w_win;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_write      <= w_sel_write;
                        r_read       <= ~w_sel_write;
                    end
                end
                S_BUSY: begin
                    if (bus.l2_resp) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_rdata = bus.l2_rdata;
    assign bus.req_resp  = w_resp;
    assign bus.l2_addr   = r_addr;
    assign bus.l2_wdata  = r_wdata;
    assign bus.l2_read   = r_read;
    assign bus.l2_write  = r_write;
    assign bus.grant_idx = r_grant_idx;
endmodule
